// File: rtl/chess_pkg.sv
// Shared definitions for the chess cursor/layout block: highlight codes,
// FSM states and the key-priority encoding.
package chess_pkg;

    localparam int unsigned HL_NONE   = 0;
    localparam int unsigned HL_CURSOR = 1;
    localparam int unsigned HL_LOCKED = 2;
    localparam int unsigned HL_BOTH   = 3;

    typedef enum logic {
        ST_SELECT = 1'b0,
        ST_LOCKED = 1'b1
    } state_e;

    typedef enum logic [2:0] {
        DIR_NONE  = 3'd0,
        DIR_LEFT  = 3'd1,
        DIR_RIGHT = 3'd2,
        DIR_UP    = 3'd3,
        DIR_DOWN  = 3'd4
    } dir_e;

    // Active-low keys, Left > Right > Up > Down.
    function automatic dir_e key_priority(input logic left_n, input logic right_n,
                                          input logic up_n, input logic down_n);
        if (!left_n)  return DIR_LEFT;
        if (!right_n) return DIR_RIGHT;
        if (!up_n)    return DIR_UP;
        if (!down_n)  return DIR_DOWN;
        return DIR_NONE;
    endfunction

endpackage

// File: rtl/chess_key_repeat.sv
// Samples the buttons on MoveTick and emits a one-cycle direction strobe:
// immediately on a new winning key, then every REPEAT_TICKS ticks while held.
module chess_key_repeat
    import chess_pkg::*;
#(
    parameter int unsigned REPEAT_TICKS = 5
) (
    input  logic clock,
    input  logic reset_app,
    input  logic move_tick,
    input  logic key_left_n,
    input  logic key_right_n,
    input  logic key_up_n,
    input  logic key_down_n,
    output dir_e move_dir_c
);
    localparam int unsigned CNT_W = $clog2(REPEAT_TICKS + 1);

    dir_e             last_q, last_d;
    dir_e             win;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // cnt_q counts ticks since the last emitted move of the held key.
    always_comb begin
        last_d     = last_q;
        cnt_d      = cnt_q;
        move_dir_c = DIR_NONE;
        win        = key_priority(key_left_n, key_right_n, key_up_n, key_down_n);
        if (move_tick) begin
            if (win == DIR_NONE) begin
                last_d = DIR_NONE;
                cnt_d  = '0;
            end else if (win != last_q || cnt_q == CNT_W'(REPEAT_TICKS)) begin
                move_dir_c = win;
                last_d     = win;
                cnt_d      = CNT_W'(1);
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset_app) begin
            last_q <= DIR_NONE;
            cnt_q  <= '0;
        end else begin
            last_q <= last_d;
            cnt_q  <= cnt_d;
        end
    end

endmodule

// File: rtl/chess_cursor_layout.sv
// Board cursor with select/lock/commit of a piece move; publishes the board
// as a registered flat vector with per-square highlight codes.
module chess_cursor_layout
    import chess_pkg::*;
#(
    parameter int unsigned BOARD_COLS   = 8,
    parameter int unsigned BOARD_ROWS   = 8,
    parameter int unsigned SQUARE_WIDTH = 8,
    parameter int unsigned PIECE_WIDTH  = 4,
    parameter bit          WRAP_EN      = 1'b1,
    parameter int unsigned START_X      = 2,
    parameter int unsigned START_Y      = 3,
    parameter int unsigned REPEAT_TICKS = 5
) (
    input  logic                                              clock,
    input  logic                                              resetApp,
    input  logic                                              MoveTick,
    input  logic                                              KeyLeft,
    input  logic                                              KeyRight,
    input  logic                                              KeyUp,
    input  logic                                              KeyDown,
    input  logic                                              LockSwitch,
    input  logic [BOARD_COLS*BOARD_ROWS*SQUARE_WIDTH-1:0]     InitLayout,
    output logic [BOARD_COLS*BOARD_ROWS*SQUARE_WIDTH-1:0]     Layout,
    output logic [$clog2(BOARD_COLS*BOARD_ROWS)-1:0]          CursorIdx,
    output logic [$clog2(BOARD_COLS*BOARD_ROWS)-1:0]          LockIdx,
    output logic                                              LockValid,
    output logic                                              MoveCommit
);
    localparam int unsigned N        = BOARD_COLS * BOARD_ROWS;
    localparam int unsigned IDX_W    = $clog2(N);
    localparam int unsigned X_W      = $clog2(BOARD_COLS);
    localparam int unsigned Y_W      = $clog2(BOARD_ROWS);
    localparam int unsigned HL_W     = SQUARE_WIDTH - PIECE_WIDTH;
    localparam int unsigned LAYOUT_W = N * SQUARE_WIDTH;
    localparam logic [IDX_W-1:0] RST_IDX = IDX_W'(START_Y * BOARD_COLS + START_X);

    function automatic logic [IDX_W-1:0] idx_of(input logic [X_W-1:0] x, input logic [Y_W-1:0] y);
        return IDX_W'(y) * IDX_W'(BOARD_COLS) + IDX_W'(x);
    endfunction

    function automatic logic [SQUARE_WIDTH-1:0] square_of(input logic [PIECE_WIDTH-1:0] piece,
                                                          input logic is_cur, input logic is_lock);
        int unsigned hl;
        if (is_cur && is_lock) hl = HL_BOTH;
        else if (is_cur)       hl = HL_CURSOR;
        else if (is_lock)      hl = HL_LOCKED;
        else                   hl = HL_NONE;
        return {HL_W'(hl), piece};
    endfunction

    state_e                  state_q, state_d;
    logic [X_W-1:0]          x_q, x_d;
    logic [Y_W-1:0]          y_q, y_d;
    logic [IDX_W-1:0]        cursor_idx_q, cursor_idx_d;
    logic [IDX_W-1:0]        lock_idx_q, lock_idx_d;
    logic                    commit_q, commit_d;
    logic [2:0]              sync_q, sync_d;
    logic [PIECE_WIDTH-1:0]  piece_q [N];
    logic [PIECE_WIDTH-1:0]  piece_d [N];
    logic [LAYOUT_W-1:0]     layout_q, layout_d, layout_rst;
    logic                    lock_edge;
    logic                    init_hl_unused;
    dir_e                    move_dir_c;

    chess_key_repeat #(
        .REPEAT_TICKS (REPEAT_TICKS)
    ) u_key_repeat (
        .clock       (clock),
        .reset_app   (resetApp),
        .move_tick   (MoveTick),
        .key_left_n  (KeyLeft),
        .key_right_n (KeyRight),
        .key_up_n    (KeyUp),
        .key_down_n  (KeyDown),
        .move_dir_c  (move_dir_c)
    );

    // Two synchroniser stages plus one history flop for rising-edge detection.
    always_comb begin
        sync_d    = {sync_q[1:0], LockSwitch};
        lock_edge = sync_q[1] & ~sync_q[2];
    end

    always_comb begin
        x_d = x_q;
        y_d = y_q;
        case (move_dir_c)
            DIR_LEFT: begin
                if (x_q != '0)   x_d = x_q - X_W'(1);
                else if (WRAP_EN) x_d = X_W'(BOARD_COLS - 1);
            end
            DIR_RIGHT: begin
                if (x_q != X_W'(BOARD_COLS - 1)) x_d = x_q + X_W'(1);
                else if (WRAP_EN)                x_d = '0;
            end
            DIR_UP: begin
                if (y_q != '0)   y_d = y_q - Y_W'(1);
                else if (WRAP_EN) y_d = Y_W'(BOARD_ROWS - 1);
            end
            DIR_DOWN: begin
                if (y_q != Y_W'(BOARD_ROWS - 1)) y_d = y_q + Y_W'(1);
                else if (WRAP_EN)                y_d = '0;
            end
            default: ;
        endcase
        cursor_idx_d = idx_of(x_d, y_d);
    end

    // Lock actions use the pre-move cursor held in cursor_idx_q.
    always_comb begin
        state_d    = state_q;
        lock_idx_d = lock_idx_q;
        commit_d   = 1'b0;
        piece_d    = piece_q;
        if (lock_edge) begin
            case (state_q)
                ST_SELECT: begin
                    if (piece_q[cursor_idx_q] != '0) begin
                        state_d    = ST_LOCKED;
                        lock_idx_d = cursor_idx_q;
                    end
                end
                ST_LOCKED: begin
                    state_d = ST_SELECT;
                    if (cursor_idx_q != lock_idx_q) begin
                        piece_d[cursor_idx_q] = piece_q[lock_idx_q];
                        piece_d[lock_idx_q]   = '0;
                        commit_d              = 1'b1;
                    end
                end
                default: state_d = ST_SELECT;
            endcase
        end
    end

    always_comb begin
        layout_d       = '0;
        layout_rst     = '0;
        init_hl_unused = 1'b0;
        for (int i = 0; i < N; i++) begin
            layout_d[i*SQUARE_WIDTH +: SQUARE_WIDTH] =
                square_of(piece_d[i], IDX_W'(i) == cursor_idx_d,
                          (state_d == ST_LOCKED) && (IDX_W'(i) == lock_idx_d));
            layout_rst[i*SQUARE_WIDTH +: SQUARE_WIDTH] =
                square_of(InitLayout[i*SQUARE_WIDTH +: PIECE_WIDTH], IDX_W'(i) == RST_IDX, 1'b0);
            init_hl_unused = init_hl_unused ^ (^InitLayout[i*SQUARE_WIDTH + PIECE_WIDTH +: HL_W]);
        end
    end

    always_ff @(posedge clock) begin
        if (resetApp) begin
            state_q      <= ST_SELECT;
            x_q          <= X_W'(START_X);
            y_q          <= Y_W'(START_Y);
            cursor_idx_q <= RST_IDX;
            lock_idx_q   <= '0;
            commit_q     <= 1'b0;
            sync_q       <= '0;
            layout_q     <= layout_rst;
            for (int i = 0; i < N; i++) begin
                piece_q[i] <= InitLayout[i*SQUARE_WIDTH +: PIECE_WIDTH];
            end
        end else begin
            state_q      <= state_d;
            x_q          <= x_d;
            y_q          <= y_d;
            cursor_idx_q <= cursor_idx_d;
            lock_idx_q   <= lock_idx_d;
            commit_q     <= commit_d;
            sync_q       <= sync_d;
            layout_q     <= layout_d;
            piece_q      <= piece_d;
        end
    end

    assign Layout     = layout_q;
    assign CursorIdx  = cursor_idx_q;
    assign LockIdx    = lock_idx_q;
    assign LockValid  = (state_q == ST_LOCKED);
    assign MoveCommit = commit_q;

endmodule

// File: tb/tb_chess_cursor_layout.sv
// Randomised and directed bench for chess_cursor_layout: three instances
// (8x8 wrap, 8x8 clamp, 5x3 wrap) share stimulus and a behavioural board model.
module tb_chess_cursor_layout;

    localparam int REP = 5;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic         resetApp, MoveTick, KeyLeft, KeyRight, KeyUp, KeyDown, LockSwitch;
    logic [511:0] init_a;
    logic [119:0] init_b;
    logic [511:0] lay0, lay1;
    logic [119:0] lay2;
    logic [5:0]   cur0, cur1, lidx0, lidx1;
    logic [3:0]   cur2, lidx2;
    logic         lv0, lv1, lv2, mc0, mc1, mc2;

    chess_cursor_layout dut0 (
        .clock(clock), .resetApp(resetApp), .MoveTick(MoveTick),
        .KeyLeft(KeyLeft), .KeyRight(KeyRight), .KeyUp(KeyUp), .KeyDown(KeyDown),
        .LockSwitch(LockSwitch), .InitLayout(init_a), .Layout(lay0),
        .CursorIdx(cur0), .LockIdx(lidx0), .LockValid(lv0), .MoveCommit(mc0));

    chess_cursor_layout #(.WRAP_EN(1'b0)) dut1 (
        .clock(clock), .resetApp(resetApp), .MoveTick(MoveTick),
        .KeyLeft(KeyLeft), .KeyRight(KeyRight), .KeyUp(KeyUp), .KeyDown(KeyDown),
        .LockSwitch(LockSwitch), .InitLayout(init_a), .Layout(lay1),
        .CursorIdx(cur1), .LockIdx(lidx1), .LockValid(lv1), .MoveCommit(mc1));

    chess_cursor_layout #(.BOARD_COLS(5), .BOARD_ROWS(3), .START_X(2), .START_Y(1)) dut2 (
        .clock(clock), .resetApp(resetApp), .MoveTick(MoveTick),
        .KeyLeft(KeyLeft), .KeyRight(KeyRight), .KeyUp(KeyUp), .KeyDown(KeyDown),
        .LockSwitch(LockSwitch), .InitLayout(init_b), .Layout(lay2),
        .CursorIdx(cur2), .LockIdx(lidx2), .LockValid(lv2), .MoveCommit(mc2));

    // Reference model state, one slot per instance.
    int cols [3] = '{8, 8, 5};
    int rows [3] = '{8, 8, 3};
    int wrap [3] = '{1, 0, 1};
    int sx   [3] = '{2, 2, 2};
    int sy   [3] = '{3, 3, 1};
    int mx [3], my [3], mlk [3], mlidx [3], mcm [3];
    int mp [3][64];
    int held_dir, held_ticks;
    bit h0, h1, h2;

    int n_checks = 0;
    int n_errors = 0;
    int commits_seen = 0;

    task automatic check_eq(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            mx[k] = sx[k]; my[k] = sy[k]; mlk[k] = 0; mlidx[k] = 0; mcm[k] = 0;
            for (int i = 0; i < cols[k] * rows[k]; i++)
                mp[k][i] = (k < 2) ? int'(init_a[i*8 +: 4]) : int'(init_b[i*8 +: 4]);
        end
        held_dir = 0; held_ticks = 0;
        h0 = 0; h1 = 0; h2 = 0;
    endtask

    function automatic int step_axis(input int v, input int size, input int delta, input int wr);
        if (wr != 0) return (v + size + delta) % size;
        if (v + delta < 0 || v + delta >= size) return v;
        return v + delta;
    endfunction

    task automatic model_step();
        bit lk_edge;
        int w, d, cur;
        if (resetApp) begin
            model_reset();
        end else begin
            lk_edge = h1 && !h2;
            h2 = h1; h1 = h0; h0 = LockSwitch;
            d = 0;
            if (MoveTick) begin
                w = !KeyLeft ? 1 : !KeyRight ? 2 : !KeyUp ? 3 : !KeyDown ? 4 : 0;
                if (w == 0) begin
                    held_dir = 0; held_ticks = 0;
                end else begin
                    if (w != held_dir) begin held_dir = w; held_ticks = 0; end
                    if (held_ticks % REP == 0) d = w;
                    held_ticks++;
                end
            end
            for (int k = 0; k < 3; k++) begin
                mcm[k] = 0;
                cur = my[k] * cols[k] + mx[k];
                if (lk_edge) begin
                    if (mlk[k] == 0) begin
                        if (mp[k][cur] != 0) begin mlk[k] = 1; mlidx[k] = cur; end
                    end else begin
                        mlk[k] = 0;
                        if (cur != mlidx[k]) begin
                            mp[k][cur] = mp[k][mlidx[k]];
                            mp[k][mlidx[k]] = 0;
                            mcm[k] = 1;
                        end
                    end
                end
                case (d)
                    1: mx[k] = step_axis(mx[k], cols[k], -1, wrap[k]);
                    2: mx[k] = step_axis(mx[k], cols[k],  1, wrap[k]);
                    3: my[k] = step_axis(my[k], rows[k], -1, wrap[k]);
                    4: my[k] = step_axis(my[k], rows[k],  1, wrap[k]);
                    default: ;
                endcase
            end
        end
    endtask

    function automatic logic [511:0] exp_layout(input int k);
        logic [511:0] e;
        int hl;
        e = '0;
        for (int i = 0; i < cols[k] * rows[k]; i++) begin
            hl = 0;
            if (i == my[k] * cols[k] + mx[k]) hl += 1;
            if (mlk[k] != 0 && i == mlidx[k]) hl += 2;
            e[i*8 +: 8] = 8'(hl * 16 + mp[k][i]);
        end
        return e;
    endfunction

    function automatic int exp_cur(input int k);
        return my[k] * cols[k] + mx[k];
    endfunction

    task automatic check_all();
        check_eq("layout0", lay0, exp_layout(0));
        check_eq("cursor0", cur0, exp_cur(0));
        check_eq("lockv0", lv0, mlk[0]);
        check_eq("lockidx0", lidx0, mlidx[0]);
        check_eq("commit0", mc0, mcm[0]);
        check_eq("layout1", lay1, exp_layout(1));
        check_eq("cursor1", cur1, exp_cur(1));
        check_eq("lockv1", lv1, mlk[1]);
        check_eq("commit1", mc1, mcm[1]);
        check_eq("layout2", lay2, exp_layout(2));
        check_eq("cursor2", cur2, exp_cur(2));
        check_eq("lockv2", lv2, mlk[2]);
        check_eq("lockidx2", lidx2, mlidx[2]);
        check_eq("commit2", mc2, mcm[2]);
    endtask

    task automatic cycle();
        @(posedge clock);
        model_step();
        #1;
        check_all();
        if (mc0) commits_seen++;
    endtask

    task automatic set_keys(input int d);
        KeyLeft = (d != 1); KeyRight = (d != 2); KeyUp = (d != 3); KeyDown = (d != 4);
    endtask

    task automatic tap(input int d);
        set_keys(d); MoveTick = 1'b1; cycle();
        set_keys(0); cycle();
        MoveTick = 1'b0; cycle();
    endtask

    task automatic lock_pulse();
        LockSwitch = 1'b1; repeat (3) cycle();
        LockSwitch = 1'b0; repeat (3) cycle();
    endtask

    task automatic do_reset();
        resetApp = 1'b1; cycle(); resetApp = 1'b0; cycle();
    endtask

    logic [5:0]   prev;
    logic [119:0] mask_b;
    int           moves, tick_mask, commits_before;

    initial begin
        for (int w = 0; w < 16; w++) init_a[w*32 +: 32] = $urandom();
        for (int w = 0; w < 3; w++)  init_b[w*32 +: 32] = $urandom();
        init_b[96 +: 24] = 24'($urandom());
        init_a[26*8 +: 4] = 4'h0;
        init_a[8*8 +: 4]  = 4'h9;
        init_a[16*8 +: 4] = 4'h3;
        init_b[5*8 +: 4]  = 4'h7;
        resetApp = 1'b1; MoveTick = 1'b0; LockSwitch = 1'b0; set_keys(0);
        repeat (2) cycle();
        resetApp = 1'b0; cycle();

        check_eq("rst_cursor", cur0, 26);
        check_eq("rst_hl26", lay0[26*8+4 +: 4], 1);
        check_eq("rst_lockv", lv0, 0);

        lock_pulse();
        check_eq("lock_empty", lv0, 0);

        tap(1); tap(1); tap(1);
        check_eq("wrap_left", cur0, 31);
        check_eq("clamp_left", cur1, 24);

        tap(2); tap(3); tap(3);
        check_eq("at_8", cur0, 8);
        lock_pulse();
        check_eq("locked_8", lv0, 1);
        check_eq("lockidx_8", lidx0, 8);
        check_eq("hl_both_8", lay0[8*8+4 +: 4], 3);
        lock_pulse();
        check_eq("cancel_lv", lv0, 0);
        check_eq("cancel_piece", lay0[8*8 +: 4], 4'h9);
        check_eq("cancel_nocommit", commits_seen, 0);

        lock_pulse();
        tap(4);
        check_eq("hl_src", lay0[8*8+4 +: 4], 2);
        check_eq("hl_dst", lay0[16*8+4 +: 4], 1);
        lock_pulse();
        check_eq("dst_piece", lay0[16*8 +: 4], 4'h9);
        check_eq("src_empty", lay0[8*8 +: 4], 4'h0);
        check_eq("commit_once", commits_seen, 1);
        check_eq("commit_lv", lv0, 0);

        // Auto-repeat over eleven held ticks.
        do_reset();
        KeyRight = 1'b0; moves = 0; tick_mask = 0;
        for (int t = 0; t < 11; t++) begin
            prev = cur0; MoveTick = 1'b1; cycle(); MoveTick = 1'b0;
            if (cur0 != prev) begin moves++; tick_mask |= (1 << t); end
            cycle(); cycle();
        end
        set_keys(0); MoveTick = 1'b1; cycle(); MoveTick = 1'b0; cycle();
        check_eq("repeat_moves", moves, 3);
        check_eq("repeat_ticks", tick_mask, 32'h421);
        check_eq("wrap_5x3", cur2, 5);

        // Reset while the 5x3 board is locked.
        lock_pulse();
        check_eq("locked_5x3", lv2, 1);
        do_reset();
        check_eq("rst_lv_5x3", lv2, 0);
        mask_b = {15{8'h0F}};
        check_eq("rst_board_5x3", lay2 & mask_b, init_b & mask_b);

        // Reset coinciding with a commit edge suppresses the commit.
        tap(1); tap(1); tap(3); tap(3);
        lock_pulse();
        tap(4);
        commits_before = commits_seen;
        LockSwitch = 1'b1; cycle(); cycle();
        resetApp = 1'b1; cycle();
        resetApp = 1'b0; LockSwitch = 1'b0; repeat (4) cycle();
        check_eq("rst_commit_none", commits_seen, commits_before);
        check_eq("rst_commit_board", lay0[16*8 +: 4], 4'h3);
        check_eq("rst_commit_lv", lv0, 0);

        for (int c = 0; c < 3000; c++) begin
            resetApp = ($urandom_range(0, 399) == 0);
            MoveTick = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 9) == 0) begin
                KeyLeft  = ($urandom_range(0, 3) != 0);
                KeyRight = ($urandom_range(0, 3) != 0);
                KeyUp    = ($urandom_range(0, 3) != 0);
                KeyDown  = ($urandom_range(0, 3) != 0);
            end
            if ($urandom_range(0, 7) == 0) LockSwitch = ~LockSwitch;
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
